// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state encoding and ALU function codes for the multi-cycle controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JGE  = 4'h5;
    localparam logic [3:0] OP_JNE  = 4'h6;
    localparam logic [3:0] OP_STOP = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;

    localparam logic [2:0] FS_ADD   = 3'd1;
    localparam logic [2:0] FS_SUB   = 3'd2;
    localparam logic [2:0] FS_PASSB = 3'd3;
    localparam logic [2:0] FS_INC   = 3'd4;
    localparam logic [2:0] FS_PASSA = 3'd5;
    localparam logic [2:0] FS_AND   = 3'd6;
    localparam logic [2:0] FS_OR    = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // ALU function applied when a memory-operand instruction completes its read.
    function automatic logic [2:0] mem_fs(input logic [3:0] op);
        logic [2:0] fs;
        fs = FS_PASSB;
        case (op)
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  fs = FS_SUB;
            OP_AND:  fs = FS_AND;
            OP_OR:   fs = FS_OR;
            default: fs = FS_PASSB;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive stalled memory cycles and flags a timeout at MAX_WAIT.
// Latency: timeout_o is combinational from the registered count and mem_rdy_i.
// Backpressure: counts only while a request is outstanding and memory is not ready.
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memrq_i,
    input  logic mem_rdy_i,
    input  logic state_chg_i,
    output logic timeout_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Next count: restart on completion or any state change, otherwise count stalls.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (mem_rdy_i || state_chg_i) begin
            wait_cnt_d = '0;
        end else if (memrq_i) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A ready response in the limit cycle still wins over the timeout.
    assign timeout_o = memrq_i && !mem_rdy_i && (wait_cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle FETCH/EXEC/HALT/FAULT controller for the accumulator CPU, with retired-instruction count.
// Latency: 1 cycle FETCH + 1 cycle EXEC per instruction at zero wait states; outputs are combinational.
// Backpressure: memrq holds while mem_rdy=0, up to MAX_WAIT stalls, then FAULT. Macro CTRL_ILLEGAL_TRAP_EN traps illegal opcodes.
module ctrl_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int FS_W     = 3,
    parameter int MAX_WAIT = 15,
    parameter int ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic              acc_msb,
    input  logic              accz,
    input  logic              mem_rdy,
    output logic              ir_ce,
    output logic              pc_ce,
    output logic              acc_ce,
    output logic              acc_oe,
    output logic              a_sel,
    output logic              b_sel,
    output logic [FS_W-1:0]   alu_fs,
    output logic              memrq,
    output logic              rnw,
    output logic              halted,
    output logic              fault,
    output logic [ICNT_W-1:0] icount
);
    state_t              state_q;
    state_t              state_d;
    logic [ICNT_W-1:0]   icount_q;
    logic                timeout;
    logic                retire;

    ctrl_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .memrq_i     (memrq),
        .mem_rdy_i   (mem_rdy),
        .state_chg_i (state_d != state_q),
        .timeout_o   (timeout)
    );

    // Next state and datapath controls; reset forces every output idle.
    always_comb begin
        state_d = state_q;
        ir_ce   = 1'b0;
        pc_ce   = 1'b0;
        acc_ce  = 1'b0;
        acc_oe  = 1'b0;
        a_sel   = 1'b0;
        b_sel   = 1'b0;
        alu_fs  = '0;
        memrq   = 1'b0;
        rnw     = 1'b1;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                memrq = 1'b1;
                if (mem_rdy) begin
                    ir_ce   = 1'b1;
                    pc_ce   = 1'b1;
                    alu_fs  = FS_W'(FS_INC);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (in_opcode)
                    OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB),
                    OPC_W'(OP_AND), OPC_W'(OP_OR): begin
                        memrq = 1'b1;
                        a_sel = 1'b1;
                        if (mem_rdy) begin
                            acc_ce = 1'b1;
                            b_sel  = 1'b1;
                            alu_fs = FS_W'(mem_fs(in_opcode[3:0]));
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OPC_W'(OP_STO): begin
                        memrq  = 1'b1;
                        rnw    = 1'b0;
                        a_sel  = 1'b1;
                        acc_oe = 1'b1;
                        if (!mem_rdy) begin
                            state_d = ST_EXEC;
                        end
                    end
                    OPC_W'(OP_JMP), OPC_W'(OP_JGE), OPC_W'(OP_JNE): begin
                        if ((in_opcode == OPC_W'(OP_JMP)) ||
                            (in_opcode == OPC_W'(OP_JGE) && !acc_msb) ||
                            (in_opcode == OPC_W'(OP_JNE) && !accz)) begin
                            pc_ce  = 1'b1;
                            a_sel  = 1'b1;
                            alu_fs = FS_W'(FS_PASSA);
                        end
                    end
                    OPC_W'(OP_STOP): begin
                        state_d = ST_HALT;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = ST_FAULT;
`else
                        state_d = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
        // Stall limit reached without a ready response.
        if (timeout) begin
            state_d = ST_FAULT;
        end
        if (!rst_n) begin
            ir_ce  = 1'b0;
            pc_ce  = 1'b0;
            acc_ce = 1'b0;
            acc_oe = 1'b0;
            a_sel  = 1'b0;
            b_sel  = 1'b0;
            alu_fs = '0;
            memrq  = 1'b0;
            rnw    = 1'b1;
            halted = 1'b0;
            fault  = 1'b0;
        end
    end

    assign retire = (state_q == ST_EXEC) && ((state_d == ST_FETCH) || (state_d == ST_HALT));

    // State register; HALT and FAULT are left only through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icount_q <= '0;
        end else if (retire) begin
            icount_q <= icount_q + ICNT_W'(1);
        end
    end

    assign icount = icount_q;

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Directed self-checking bench for the multi-cycle controller.
// Latency: inputs change on the falling edge, outputs are checked 1 ns later.
// Backpressure: mem_rdy is driven per cycle by each scenario.
module tb_ctrl_fsm_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_opcode = 4'h0;
    logic        acc_msb = 1'b0;
    logic        accz = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        ir_ce, pc_ce, acc_ce, acc_oe, a_sel, b_sel, memrq, rnw, halted, fault;
    logic [2:0]  alu_fs;
    logic [15:0] icount;
    int          checks = 0;
    int          errors = 0;

    // {ir_ce,pc_ce,acc_ce,acc_oe}_{a_sel,b_sel}_{alu_fs}_{memrq,rnw,halted,fault}
    wire [12:0] outs = {ir_ce, pc_ce, acc_ce, acc_oe, a_sel, b_sel, alu_fs, memrq, rnw, halted, fault};

    localparam logic [12:0] O_IDLE  = 13'b0000_00_000_0100;
    localparam logic [12:0] O_FWAIT = 13'b0000_00_000_1100;
    localparam logic [12:0] O_FDONE = 13'b1100_00_100_1100;
    localparam logic [12:0] O_LDA   = 13'b0010_11_011_1100;
    localparam logic [12:0] O_ADD   = 13'b0010_11_001_1100;
    localparam logic [12:0] O_MWAIT = 13'b0000_10_000_1100;
    localparam logic [12:0] O_STO   = 13'b0001_10_000_1000;
    localparam logic [12:0] O_JMP   = 13'b0100_10_101_0100;
    localparam logic [12:0] O_HALT  = 13'b0000_00_000_0110;
    localparam logic [12:0] O_FAULT = 13'b0000_00_000_0101;

    ctrl_fsm_mc u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_opcode (in_opcode),
        .acc_msb   (acc_msb),
        .accz      (accz),
        .mem_rdy   (mem_rdy),
        .ir_ce     (ir_ce),
        .pc_ce     (pc_ce),
        .acc_ce    (acc_ce),
        .acc_oe    (acc_oe),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .alu_fs    (alu_fs),
        .memrq     (memrq),
        .rnw       (rnw),
        .halted    (halted),
        .fault     (fault),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus with reset released; outputs settle 1 ns after the falling edge.
    task automatic cyc(input logic [3:0] op, input logic rdy, input logic msb, input logic z);
        @(negedge clk);
        rst_n     = 1'b1;
        in_opcode = op;
        mem_rdy   = rdy;
        acc_msb   = msb;
        accz      = z;
        #1;
    endtask

    // Hold reset for one rising edge with a ready memory, checking outputs stay idle.
    task automatic test_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_rdy   = 1'b1;
        in_opcode = 4'h0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_idle_%s got %b exp %b", tag, outs, O_IDLE);
        end
    endtask

    task automatic test_lda;
        test_reset("lda");
        cyc(4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (icount !== 16'd0) begin errors++; $display("FAIL reset_icount got %0d exp 0", icount); end
        checks++;
        if (outs !== O_FDONE) begin errors++; $display("FAIL lda_fetch got %b exp %b", outs, O_FDONE); end
        cyc(4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_LDA) begin errors++; $display("FAIL lda_exec got %b exp %b", outs, O_LDA); end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_FWAIT) begin errors++; $display("FAIL lda_back_fetch got %b exp %b", outs, O_FWAIT); end
        checks++;
        if (icount !== 16'd1) begin errors++; $display("FAIL lda_icount got %0d exp 1", icount); end
    endtask

    task automatic test_add_wait;
        cyc(4'h2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'h2, 1'b0, 1'b0, 1'b0);
            checks++;
            if (outs !== O_MWAIT) begin errors++; $display("FAIL add_wait%0d got %b exp %b", i, outs, O_MWAIT); end
        end
        cyc(4'h2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_ADD) begin errors++; $display("FAIL add_done got %b exp %b", outs, O_ADD); end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_FWAIT) begin errors++; $display("FAIL add_no_fault got %b exp %b", outs, O_FWAIT); end
        checks++;
        if (icount !== 16'd2) begin errors++; $display("FAIL add_icount got %0d exp 2", icount); end
    endtask

    task automatic test_timeout;
        test_reset("tmo");
        for (int i = 1; i <= 16; i++) begin
            cyc(4'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (outs !== O_FWAIT) begin errors++; $display("FAIL tmo_wait%0d got %b exp %b", i, outs, O_FWAIT); end
        end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_FAULT) begin errors++; $display("FAIL tmo_fault17 got %b exp %b", outs, O_FAULT); end
        for (int i = 0; i < 3; i++) begin
            cyc(4'h4, 1'b1, 1'b0, 1'b0);
            checks++;
            if (outs !== O_FAULT) begin errors++; $display("FAIL tmo_sticky%0d got %b exp %b", i, outs, O_FAULT); end
        end
        checks++;
        if (icount !== 16'd0) begin errors++; $display("FAIL tmo_icount got %0d exp 0", icount); end
    endtask

    // Ready arriving in the limit cycle completes the fetch instead of faulting.
    task automatic test_wait_limit;
        test_reset("lim");
        for (int i = 1; i <= 15; i++) begin
            cyc(4'h4, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'h4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_FDONE) begin errors++; $display("FAIL lim_fetch16 got %b exp %b", outs, O_FDONE); end
        cyc(4'h4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_JMP) begin errors++; $display("FAIL lim_jmp_exec got %b exp %b", outs, O_JMP); end
    endtask

    task automatic test_jumps;
        test_reset("jmp");
        cyc(4'h5, 1'b1, 1'b1, 1'b0);
        cyc(4'h5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL jge_not_taken got %b exp %b", outs, O_IDLE); end
        cyc(4'h6, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== O_FDONE) begin errors++; $display("FAIL jge_next_fetch got %b exp %b", outs, O_FDONE); end
        cyc(4'h6, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_JMP) begin errors++; $display("FAIL jne_taken got %b exp %b", outs, O_JMP); end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (icount !== 16'd2) begin errors++; $display("FAIL jmp_icount got %0d exp 2", icount); end
    endtask

    task automatic test_sto_stop;
        test_reset("sto");
        cyc(4'h1, 1'b1, 1'b0, 1'b0);
        cyc(4'h1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_STO) begin errors++; $display("FAIL sto_wait got %b exp %b", outs, O_STO); end
        cyc(4'h1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_STO) begin errors++; $display("FAIL sto_done got %b exp %b", outs, O_STO); end
        cyc(4'h7, 1'b1, 1'b0, 1'b0);
        cyc(4'h7, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL stop_exec got %b exp %b", outs, O_IDLE); end
        for (int i = 0; i < 3; i++) begin
            cyc(4'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (outs !== O_HALT) begin errors++; $display("FAIL halt%0d got %b exp %b", i, outs, O_HALT); end
        end
        checks++;
        if (icount !== 16'd2) begin errors++; $display("FAIL halt_icount got %0d exp 2", icount); end
        test_reset("halt");
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== O_FWAIT) begin errors++; $display("FAIL halt_exit got %b exp %b", outs, O_FWAIT); end
        checks++;
        if (icount !== 16'd0) begin errors++; $display("FAIL halt_exit_icount got %0d exp 0", icount); end
    endtask

    task automatic test_illegal;
        test_reset("ill");
        cyc(4'hC, 1'b1, 1'b0, 1'b0);
        cyc(4'hC, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL ill_exec got %b exp %b", outs, O_IDLE); end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++;
        if (outs !== O_FAULT) begin errors++; $display("FAIL ill_trap got %b exp %b", outs, O_FAULT); end
        checks++;
        if (icount !== 16'd0) begin errors++; $display("FAIL ill_icount got %0d exp 0", icount); end
`else
        checks++;
        if (outs !== O_FWAIT) begin errors++; $display("FAIL ill_nop got %b exp %b", outs, O_FWAIT); end
        checks++;
        if (icount !== 16'd1) begin errors++; $display("FAIL ill_icount got %0d exp 1", icount); end
`endif
    endtask

    initial begin
        test_lda();
        test_add_wait();
        test_timeout();
        test_wait_limit();
        test_jumps();
        test_sto_stop();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
